// File: rtl/text_tag_word_counter.sv
// Streaming word counter: finds "DLAB_TAG", then counts letter runs of exactly WORD_LEN
// until "DLAB_END", using an 8-byte delay window so tag bytes never reach the word logic.
module text_tag_word_counter #(
  parameter int unsigned WORD_LEN  = 3,
  parameter int unsigned COUNT_W   = 16,
  parameter logic [31:0] MAX_BYTES = 32'd4194304
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [7:0]         byte_data,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic               found_start,
  output logic               done,
  output logic               error,
  output logic [COUNT_W-1:0] word_count
);

  localparam logic [63:0] StartTag = "DLAB_TAG";
  localparam logic [63:0] EndTag   = "DLAB_END";
  localparam logic [7:0]  RunMax   = 8'hFF;
  localparam logic [7:0]  WordLen8 = 8'(WORD_LEN);

  typedef enum logic [1:0] {StIdle, StSearch, StScan, StDone} state_e;

  state_e               state_q, state_d;
  logic [63:0]          window_q, window_d;
  logic [3:0]           fill_q, fill_d;
  logic [7:0]           run_q, run_d;
  logic [31:0]          bytes_q, bytes_d;
  logic                 found_q, found_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic [COUNT_W-1:0]   count_q, count_d;

  logic [63:0]          shifted;
  logic [7:0]           evict;
  logic [31:0]          bytes_inc;
  logic [7:0]           run_after;
  logic [COUNT_W-1:0]   count_after, term_count;
  logic                 accept;

  function automatic logic is_letter(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
  endfunction

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == '1) ? v : v + COUNT_W'(1);
  endfunction

  assign byte_ready  = (state_q == StSearch) || (state_q == StScan);
  assign found_start = found_q;
  assign done        = done_q;
  assign error       = error_q;
  assign word_count  = count_q;

  assign accept    = byte_valid && byte_ready;
  assign shifted   = {window_q[55:0], byte_data};
  assign evict     = window_q[63:56];
  assign bytes_inc = bytes_q + 32'd1;

  // Word logic applied to the byte leaving the delay window (only once it is full).
  always_comb begin
    run_after   = run_q;
    count_after = count_q;
    if (fill_q == 4'd8) begin
      if (is_letter(evict)) begin
        run_after = (run_q == RunMax) ? run_q : run_q + 8'd1;
      end else begin
        if (run_q == WordLen8) count_after = sat_inc(count_q);
        run_after = 8'd0;
      end
    end
    // End tag closes the pending run as if a non-letter followed.
    term_count = (run_after == WordLen8) ? sat_inc(count_after) : count_after;
  end

  always_comb begin
    state_d  = state_q;
    window_d = window_q;
    fill_d   = fill_q;
    run_d    = run_q;
    bytes_d  = bytes_q;
    found_d  = found_q;
    done_d   = done_q;
    error_d  = error_q;
    count_d  = count_q;

    if (start) begin
      state_d  = StSearch;
      window_d = 64'h0;
      fill_d   = 4'd0;
      run_d    = 8'd0;
      bytes_d  = 32'd0;
      found_d  = 1'b0;
      done_d   = 1'b0;
      error_d  = 1'b0;
      count_d  = '0;
    end else if (accept) begin
      window_d = shifted;
      bytes_d  = bytes_inc;
      fill_d   = (fill_q == 4'd8) ? 4'd8 : fill_q + 4'd1;
      if (bytes_inc == MAX_BYTES) begin
        done_d  = 1'b1;
        error_d = 1'b1;
        state_d = StDone;
      end else if (state_q == StSearch) begin
        if (shifted == StartTag) begin
          state_d = StScan;
          found_d = 1'b1;
          fill_d  = 4'd0;
          run_d   = 8'd0;
        end
      end else begin
        if (shifted == EndTag) begin
          count_d = term_count;
          run_d   = 8'd0;
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          run_d   = run_after;
          count_d = count_after;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      window_q <= 64'h0;
      fill_q   <= 4'd0;
      run_q    <= 8'd0;
      bytes_q  <= 32'd0;
      found_q  <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      window_q <= window_d;
      fill_q   <= fill_d;
      run_q    <= run_d;
      bytes_q  <= bytes_d;
      found_q  <= found_d;
      done_q   <= done_d;
      error_q  <= error_d;
      count_q  <= count_d;
    end
  end

endmodule
